// File: rtl/sr_tx_arbiter.sv
// sr_tx_arbiter: round-robin scheduler of two parallel-word requesters onto
// one MSB-first serial line, with back-to-back words and a frame marker.
module sr_tx_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame,
    output logic             src
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic             last_q;
    logic             src_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             frame_q;
    logic             valid_q;

    logic             pick1_c;
    logic             accept_c;

    // Arbitration: a lone request wins; on contention the requester not served last wins.
    always_comb begin
        pick1_c  = 1'b0;
        accept_c = 1'b0;
        pick1_c  = req1 & (~req0 | ~last_q);
        accept_c = (req0 | req1) & ((state_q == IDLE) | (cnt_q == CW'(0)));
    end

    // Controller: load on accept, shift while counting down, idle when no work.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            last_q  <= 1'b1;
            src_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            frame_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            frame_q <= 1'b0;
            if (accept_c) begin
                state_q <= SHIFT;
                sr_q    <= pick1_c ? data1 : data0;
                cnt_q   <= CW'(WIDTH - 1);
                src_q   <= pick1_c;
                last_q  <= pick1_c;
                gnt0_q  <= ~pick1_c;
                gnt1_q  <= pick1_c;
                frame_q <= 1'b1;
                valid_q <= 1'b1;
            end else if (state_q == SHIFT) begin
                if (cnt_q != CW'(0)) begin
                    sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - CW'(1);
                end else begin
                    state_q <= IDLE;
                    sr_q    <= '0;
                    src_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign ser_out   = sr_q[WIDTH-1];
    assign ser_valid = valid_q;
    assign frame     = frame_q;
    assign src       = src_q;

endmodule

// File: tb/tb_sr_tx_arbiter.sv
// Directed bench for sr_tx_arbiter: reset, single word, contention,
// fairness, abort and a late single requester, checked cycle by cycle.
module tb_sr_tx_arbiter;

    logic       clk;
    logic       clr;
    logic       req0;
    logic [7:0] data0;
    logic       gnt0;
    logic       req1;
    logic [7:0] data1;
    logic       gnt1;
    logic       ser_out;
    logic       ser_valid;
    logic       frame;
    logic       src;

    int vecs;
    int errs;

    sr_tx_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .req0      (req0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .data1     (data1),
        .gnt1      (gnt1),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .frame     (frame),
        .src       (src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output vector: {gnt0, gnt1, ser_valid, frame, ser_out, src}
    function automatic logic [5:0] outs();
        return {gnt0, gnt1, ser_valid, frame, ser_out, src};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Idle: no grant, no valid, no frame, ser_out low (src not checked).
    task automatic check_idle(input string tag);
        logic [5:0] o;
        o = outs();
        vecs++;
        assert (o[5:1] === 5'b0) else begin
            errs++;
            $error("FAIL %s observed=%b expected=00000", tag, o[5:1]);
        end
    endtask

    // Check nbits cycles of one word starting at the cycle after its accept edge.
    task automatic expect_word(input string tag, input logic id, input logic [7:0] d,
                               input logic [1:0] dropm, input int nbits);
        logic [5:0] e;
        for (int k = 0; k < nbits; k++) begin
            tick();
            e = {(k == 0) && !id, (k == 0) && id, 1'b1, k == 0, d[7-k], id};
            check($sformatf("%s_bit%0d", tag, k), outs(), e);
            if (k == 0) begin
                if (dropm[0]) req0 = 1'b0;
                if (dropm[1]) req1 = 1'b0;
            end
        end
    endtask

    initial begin
        vecs  = 0;
        errs  = 0;
        clr   = 1'b1;
        req0  = 1'b1;
        data0 = 8'hFF;
        req1  = 1'b0;
        data1 = 8'h00;

        // Reset held two edges with a pending request: nothing captured.
        tick();
        check("reset_e1", outs(), 6'b0);
        tick();
        check("reset_e2", outs(), 6'b0);
        clr  = 1'b0;
        req0 = 1'b0;
        tick();
        check("post_reset_idle", outs(), 6'b0);

        // Single word A5 from requester 0.
        req0  = 1'b1;
        data0 = 8'hA5;
        expect_word("single", 1'b0, 8'hA5, 2'b01, 8);
        tick();
        check_idle("single_idle");

        // Contention from reset: 0 then 1 with no gap.
        clr = 1'b1;
        tick();
        check("clr_pulse", outs(), 6'b0);
        clr   = 1'b0;
        req0  = 1'b1;
        data0 = 8'hA5;
        req1  = 1'b1;
        data1 = 8'h3C;
        expect_word("cont_w0", 1'b0, 8'hA5, 2'b01, 8);
        expect_word("cont_w1", 1'b1, 8'h3C, 2'b10, 8);
        tick();
        check_idle("cont_idle");

        // Fairness: both held for 4 words -> 0,1,0,1 every 8 cycles.
        req0  = 1'b1;
        data0 = 8'h5A;
        req1  = 1'b1;
        data1 = 8'hC3;
        expect_word("fair_w0", 1'b0, 8'h5A, 2'b00, 8);
        expect_word("fair_w1", 1'b1, 8'hC3, 2'b00, 8);
        expect_word("fair_w2", 1'b0, 8'h5A, 2'b00, 8);
        expect_word("fair_w3", 1'b1, 8'hC3, 2'b11, 8);
        tick();
        check_idle("fair_idle");

        // Abort a requester-1 word during bit 3; pointer returns to favour 0.
        req1  = 1'b1;
        data1 = 8'hF0;
        expect_word("abort_w", 1'b1, 8'hF0, 2'b00, 3);
        clr   = 1'b1;
        req0  = 1'b1;
        data0 = 8'h96;
        tick();
        check("abort_clr", outs(), 6'b0);
        clr = 1'b0;
        expect_word("abort_r0", 1'b0, 8'h96, 2'b11, 8);
        tick();
        check_idle("abort_idle");

        // Late single requester 1 with 81.
        tick();
        check_idle("late_pre_idle");
        req1  = 1'b1;
        data1 = 8'h81;
        expect_word("late", 1'b1, 8'h81, 2'b10, 8);
        tick();
        check_idle("late_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
